multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//   Multi-cycle control FSM for the RV32I integer datapath (R-type, I-ALU, load, store).
//   Sequences one instruction over FETCH/DECODE/EXEC/MEM/WB on a shared instruction/data
//   memory with a ready handshake. Drives the same datapath select/enable set as the
//   single-cycle decoder, plus the IR, PC and memory-address controls.
// PARAMETERS
//   OPCODE_W  7   opcode field width (instr[6:0])
//   CNT_W     32  width of the retired-instruction counter
// PORTS
//   clk           in   1        rising-edge clock
//   rst_n         in   1        asynchronous active-low reset
//   Opcode        in   OPCODE_W opcode from IR; sampled only in DECODE
//   MemReady      in   1        memory completed the current request; may be high in the request cycle
//   Stall         in   1        blocks issue of a new fetch; in-flight instruction completes
//   IRWrite       out  1        load IR from memory read data
//   PCWrite       out  1        load PC from ALU result (PC+4)
//   IorD          out  1        memory address: 0 = PC, 1 = ALU result
//   MemRead       out  1        memory read request (level, held until MemReady)
//   MemWrite      out  1        memory write request (level, held until MemReady)
//   ALUSrcA       out  1        ALU A: 0 = PC, 1 = rs1
//   ALUSrcB       out  2        ALU B: 00 = rs2, 01 = const 4, 10 = immediate
//   ALUOp         out  2        10 = R-type funct decode, 00 = I-ALU funct decode, 01 = add
//   MemtoReg      out  1        writeback source: 1 = memory data, 0 = ALU result
//   RegWrite      out  1        register-file write enable
//   InstrRetired  out  1        one-cycle pulse when an instruction completes
//   RetireCount   out  CNT_W    retired-instruction count, wraps to 0
//   IllegalInstr  out  1        unsupported opcode trapped (ILLEGAL_TRAP_EN only; else tied 0)
// BEHAVIOUR
//   - Reset (rst_n low, async): state = IDLE, class = NONE, RetireCount = 0; every output 0.
//   - Outputs are Moore, decoded from the registered state and latched class only. Any output
//     not listed for a state is 0.
//   - IDLE: all outputs 0. -> FETCH when Stall = 0; otherwise stay in IDLE.
//   - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=01.
//     IRWrite = PCWrite = MemReady. Stay in FETCH until MemReady, then -> DECODE.
//   - DECODE: latch class from Opcode: 0110011 = R, 0010011 = IALU, 0000011 = LOAD,
//     0100011 = STORE, anything else = ILLEGAL. Supported class -> EXEC. ILLEGAL: see CONFIGURATION.
//   - EXEC (1 cycle): ALUSrcA=1.
//     R: ALUSrcB=00, ALUOp=10. IALU: ALUSrcB=10, ALUOp=00. LOAD/STORE: ALUSrcB=10, ALUOp=01.
//     R/IALU -> WB; LOAD/STORE -> MEM.
//   - MEM: IorD=1, ALUSrcA=1, ALUSrcB=10, ALUOp=01 (address held stable).
//     LOAD drives MemRead=1; STORE drives MemWrite=1. Wait for MemReady.
//     On MemReady: LOAD -> WB; STORE retires and goes to FETCH (IDLE if Stall=1).
//   - WB (1 cycle): RegWrite=1; MemtoReg=1 for LOAD, else 0. Retire, then -> FETCH (IDLE if Stall=1).
//   - Retire: InstrRetired=1 for exactly the completing cycle; RetireCount += 1 on the next edge.
//     All-ones wraps to 0.
//   - Latency with MemReady tied high: R/IALU = 4 cycles, LOAD = 5, STORE = 4.
//     Each memory wait cycle adds 1.
//   - Stall is sampled only at IDLE exit and at retire. A Stall in any other state has no effect.
//   - MemReady outside FETCH/MEM is ignored. MemRead and MemWrite are never both 1.
//   - Reset mid-instruction: immediate return to IDLE with all outputs 0.
//     The partial instruction is discarded and not counted.
// CONFIGURATION
//   ILLEGAL_TRAP_EN defined: an ILLEGAL class in DECODE goes to TRAP.
//     TRAP: IllegalInstr=1, all other control outputs 0, no retire. Only rst_n leaves TRAP.
//   ILLEGAL_TRAP_EN undefined: an ILLEGAL class is a NOP. DECODE retires it (pulse, count += 1)
//     and goes to FETCH/IDLE. IllegalInstr is tied 0 and there is no TRAP state.
// TESTING
//   - Reset: assert rst_n=0 mid-MEM of a load -> all outputs 0 and RetireCount=0 immediately.
//     Release with Stall=0 -> IDLE, then FETCH with MemRead=1.
//   - R-type 0110011 with MemReady=1: IRWrite/PCWrite in cycle 1; EXEC shows ALUSrcB=00, ALUOp=10;
//     WB RegWrite=1, MemtoReg=0; InstrRetired in cycle 4 -> RetireCount=1.
//   - Load 0000011 with MemReady low for 3 MEM cycles: MemRead and IorD=1 held for 4 cycles;
//     then WB RegWrite=1, MemtoReg=1; total 8 cycles.
//   - Store 0100011: MEM MemWrite=1, MemRead=0, RegWrite never 1; retire from MEM -> RetireCount += 1.
//   - Stall=1 during an IALU EXEC: instruction completes and retires, then IDLE holds.
//     Drop Stall -> FETCH the next cycle.
//   - Opcode 1111111: with ILLEGAL_TRAP_EN -> TRAP, IllegalInstr=1 held over 10 cycles, count unchanged.
//     Without ILLEGAL_TRAP_EN -> retire pulse in DECODE, count +1.
//     Preload RetireCount all-ones -> wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (R-type, I-ALU, load, store) over a shared memory with ready handshake.
// Optional macro ILLEGAL_TRAP_EN: unsupported opcodes trap (TRAP state) instead of retiring as NOPs.
module multicycle_controller #(
  parameter int OPCODE_W = 7,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  input  logic                Stall,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                InstrRetired,
  output logic [CNT_W-1:0]    RetireCount,
  output logic                IllegalInstr
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_IALU, C_LOAD, C_STORE, C_ILLEGAL
  } class_e;

  function automatic class_e decode_class(input logic [OPCODE_W-1:0] op);
    if (op == OPCODE_W'(7'b0110011))      return C_R;
    else if (op == OPCODE_W'(7'b0010011)) return C_IALU;
    else if (op == OPCODE_W'(7'b0000011)) return C_LOAD;
    else if (op == OPCODE_W'(7'b0100011)) return C_STORE;
    else                                  return C_ILLEGAL;
  endfunction

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire_s;
  logic             iord_q, iord_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic             alu_src_a_q, alu_src_a_d, mem_to_reg_q, mem_to_reg_d;
  logic             reg_write_q, reg_write_d, illegal_q, illegal_d;
  logic [1:0]       alu_src_b_q, alu_src_b_d, alu_op_q, alu_op_d;

  // Next state, class latch and retire detection.
  always_comb begin
    state_d  = state_q;
    class_d  = class_q;
    retire_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!Stall) state_d = S_FETCH;
        else        state_d = S_IDLE;
      end
      S_FETCH: begin
        if (MemReady) state_d = S_DECODE;
        else          state_d = S_FETCH;
      end
      S_DECODE: begin
        class_d = decode_class(Opcode);
        if (class_d == C_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          retire_s = 1'b1;
          state_d  = Stall ? S_IDLE : S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (class_q == C_LOAD || class_q == C_STORE) state_d = S_MEM;
        else                                         state_d = S_WB;
      end
      S_MEM: begin
        if (!MemReady) begin
          state_d = S_MEM;
        end else if (class_q == C_STORE) begin
          retire_s = 1'b1;
          state_d  = Stall ? S_IDLE : S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        retire_s = 1'b1;
        state_d  = Stall ? S_IDLE : S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs are decoded from the upcoming state so they are registered alongside it.
  always_comb begin
    iord_d      = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_src_a_d = 1'b0;
    alu_src_b_d = 2'b00;
    alu_op_d    = 2'b00;
    mem_to_reg_d = 1'b0;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
        alu_op_d    = 2'b01;
      end
      S_EXEC: begin
        alu_src_a_d = 1'b1;
        case (class_d)
          C_R:     begin alu_src_b_d = 2'b00; alu_op_d = 2'b10; end
          C_IALU:  begin alu_src_b_d = 2'b10; alu_op_d = 2'b00; end
          C_LOAD,
          C_STORE: begin alu_src_b_d = 2'b10; alu_op_d = 2'b01; end
          default: begin alu_src_b_d = 2'b00; alu_op_d = 2'b00; end
        endcase
      end
      S_MEM: begin
        iord_d      = 1'b1;
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        alu_op_d    = 2'b01;
        mem_read_d  = (class_d == C_LOAD);
        mem_write_d = (class_d == C_STORE);
      end
      S_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = (class_d == C_LOAD);
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: illegal_d = 1'b1;
`endif
      default: illegal_d = 1'b0;
    endcase
  end

  assign count_d = count_q + CNT_W'(retire_s);

  // State, class, output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      class_q      <= C_NONE;
      count_q      <= '0;
      iord_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 2'b00;
      alu_op_q     <= 2'b00;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      class_q      <= class_d;
      count_q      <= count_d;
      iord_q       <= iord_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_op_q     <= alu_op_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      illegal_q    <= illegal_d;
    end
  end

  // IR/PC load and retire depend on this cycle's handshake, so they stay combinational.
  assign IRWrite      = (state_q == S_FETCH) && MemReady;
  assign PCWrite      = (state_q == S_FETCH) && MemReady;
  assign InstrRetired = retire_s;
  assign RetireCount  = count_q;
  assign IorD         = iord_q;
  assign MemRead      = mem_read_q;
  assign MemWrite     = mem_write_q;
  assign ALUSrcA      = alu_src_a_q;
  assign ALUSrcB      = alu_src_b_q;
  assign ALUOp        = alu_op_q;
  assign MemtoReg     = mem_to_reg_q;
  assign RegWrite     = reg_write_q;
  assign IllegalInstr = illegal_q;

endmodule
